// File: rtl/ember_fetch_queue.sv
// Instruction-fetch front end: streams words from the PC, assembles instruction
// plus optional 64-bit immediate, and buffers whole bundles for the decoder.
module ember_fetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                QDEPTH   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic                         imem_rd_en,
   output logic [ADDR_W-1:0]            imem_addr,
   input  logic [31:0]                  imem_rd_data,
   input  logic                         redirect_en,
   input  logic [ADDR_W-1:0]            redirect_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_inst,
   output logic [63:0]                  out_imm,
   output logic                         out_imm_en,
   output logic [ADDR_W-1:0]            out_pc,
   output logic [$clog2(QDEPTH+1)-1:0]  out_count
);

   localparam int CW = $clog2(QDEPTH + 1);
   localparam int PW = $clog2(QDEPTH);

   typedef enum logic [1:0] {S_INST, S_IMM_LO, S_IMM_HI} asm_state_t;

   asm_state_t        state, state_nxt;
   logic [ADDR_W-1:0] fetch_pc, rsp_pc, inst_pc_q;
   logic              rsp_pending;
   logic [31:0]       inst_q, imm_lo_q;
   logic              word_vld, push, pop;
   logic [31:0]       push_inst;
   logic [63:0]       push_imm;
   logic              push_imm_en;
   logic [ADDR_W-1:0] push_pc;
   logic [CW-1:0]     count;
   logic [PW-1:0]     head, tail;
   logic              unused_pc_bits;

   logic [31:0]       q_inst   [QDEPTH];
   logic [63:0]       q_imm    [QDEPTH];
   logic              q_imm_en [QDEPTH];
   logic [ADDR_W-1:0] q_pc     [QDEPTH];

   // Words already in flight count against free space; a same-cycle pop does not.
   assign imem_rd_en = reset && !redirect_en &&
                       (({1'b0, count} + (CW+1)'(rsp_pending)) < (CW+1)'(QDEPTH));
   assign imem_addr  = fetch_pc;
   assign word_vld   = rsp_pending && !redirect_en;
   assign out_valid  = (count != '0);
   assign pop        = out_valid && out_ready && !redirect_en;
   assign out_count  = count;
   assign out_inst   = q_inst[head];
   assign out_imm    = q_imm[head];
   assign out_imm_en = q_imm_en[head];
   assign out_pc     = q_pc[head];
   assign unused_pc_bits = ^redirect_pc[1:0];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= {RESET_PC[ADDR_W-1:2], 2'b00};
         rsp_pc      <= '0;
         rsp_pending <= 1'b0;
      end else if (redirect_en) begin
         fetch_pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
         rsp_pending <= 1'b0;
      end else begin
         rsp_pending <= imem_rd_en;
         if (imem_rd_en) begin
            rsp_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_W'(4);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_INST;
         inst_q    <= '0;
         inst_pc_q <= '0;
         imm_lo_q  <= '0;
      end else begin
         state <= state_nxt;
         if (word_vld && state == S_INST) begin
            inst_q    <= imem_rd_data;
            inst_pc_q <= rsp_pc;
         end
         if (word_vld && state == S_IMM_LO) imm_lo_q <= imem_rd_data;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      state_nxt   = state;
      push        = 1'b0;
      push_inst   = inst_q;
      push_pc     = inst_pc_q;
      push_imm    = '0;
      push_imm_en = 1'b0;
      if (word_vld) begin
         case (state)
            S_INST: begin
               if (imem_rd_data[3]) begin
                  state_nxt = S_IMM_LO;
               end else begin
                  push      = 1'b1;
                  push_inst = imem_rd_data;
                  push_pc   = rsp_pc;
               end
            end
            S_IMM_LO: state_nxt = S_IMM_HI;
            S_IMM_HI: begin
               push        = 1'b1;
               push_imm    = {imem_rd_data, imm_lo_q};
               push_imm_en = 1'b1;
               state_nxt   = S_INST;
            end
            default: state_nxt = S_INST;
         endcase
      end
      if (redirect_en) state_nxt = S_INST;
   end

   // NOTE: queue storage is reset because the head entry must read as zero out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_inst[i]   <= '0;
            q_imm[i]    <= '0;
            q_imm_en[i] <= 1'b0;
            q_pc[i]     <= '0;
         end
      end else if (redirect_en) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else begin
         if (push) begin
            q_inst[tail]   <= push_inst;
            q_imm[tail]    <= push_imm;
            q_imm_en[tail] <= push_imm_en;
            q_pc[tail]     <= push_pc;
            tail           <= ptr_inc(tail);
         end
         if (pop) head <= ptr_inc(head);
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

endmodule

// File: tb/tb_ember_fetch_queue.sv
// Directed bench for ember_fetch_queue: registered word memory model plus
// per-scenario tasks with hand-computed expectations.
module tb_ember_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_rd_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd_data;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [63:0] out_imm;
   logic        out_imm_en;
   logic [31:0] out_pc;
   logic [2:0]  out_count;

   int asserts  = 0;
   int failures = 0;

   logic [31:0] mem [256];

   ember_fetch_queue #(.ADDR_W(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset),
      .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rd_data(imem_rd_data),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_imm(out_imm), .out_imm_en(out_imm_en), .out_pc(out_pc), .out_count(out_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (imem_rd_en) imem_rd_data <= mem[imem_addr[9:2]];

   always @(posedge clk)
      if (reset === 1'b1 && dut.push && dut.count == 3'd4) begin
         $display("FAIL push_while_full: push=%b count=%0d required no push at count 4", dut.push, dut.count);
         failures++;
      end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'(i) << 4;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_en = 1'b1;
      redirect_pc = pc;
      tick();
      redirect_en = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      asserts++; if (imem_rd_en !== 1'b0) begin $display("FAIL rst_rd_en: got %b expected 0", imem_rd_en); failures++; end
      asserts++; if (out_valid !== 1'b0) begin $display("FAIL rst_valid: got %b expected 0", out_valid); failures++; end
      asserts++; if (out_count !== 3'd0) begin $display("FAIL rst_count: got %0d expected 0", out_count); failures++; end
      asserts++; if (out_inst !== 32'h0) begin $display("FAIL rst_inst: got %h expected 0", out_inst); failures++; end
      asserts++; if (out_imm !== 64'h0) begin $display("FAIL rst_imm: got %h expected 0", out_imm); failures++; end
      asserts++; if (out_imm_en !== 1'b0) begin $display("FAIL rst_imm_en: got %b expected 0", out_imm_en); failures++; end
      asserts++; if (out_pc !== 32'h0) begin $display("FAIL rst_pc: got %h expected 0", out_pc); failures++; end
   endtask

   task automatic test_straight_line();
      logic [31:0] exp_inst [4];
      exp_inst[0] = 32'h1; exp_inst[1] = 32'h2; exp_inst[2] = 32'h4; exp_inst[3] = 32'h10;
      @(posedge clk); #1;
      reset     = 1'b1;
      out_ready = 1'b1;
      #1;
      asserts++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0) begin $display("FAIL straight_first_issue: got en=%b addr=%h expected en=1 addr=0", imem_rd_en, imem_addr); failures++; end
      tick();
      asserts++; if (out_valid !== 1'b0) begin $display("FAIL straight_cycle1_valid: got %b expected 0", out_valid); failures++; end
      for (int k = 0; k < 4; k++) begin
         tick();
         asserts++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_inst !== exp_inst[k] || out_imm_en !== 1'b0) begin
            $display("FAIL straight_bundle%0d: got v=%b pc=%h inst=%h imm_en=%b expected v=1 pc=%h inst=%h imm_en=0",
                     k, out_valid, out_pc, out_inst, out_imm_en, 32'(4 * k), exp_inst[k]); failures++; end
      end
   endtask

   task automatic test_immediate();
      init_mem();
      mem[0] = 32'h8; mem[1] = 32'h11223344; mem[2] = 32'hAABBCCDD;
      out_ready = 1'b1;
      redirect_to(32'h0);
      asserts++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0) begin $display("FAIL imm_issue: got en=%b addr=%h expected en=1 addr=0", imem_rd_en, imem_addr); failures++; end
      tick(); tick(); tick();
      asserts++; if (out_valid !== 1'b0) begin $display("FAIL imm_early_valid: got %b expected 0", out_valid); failures++; end
      tick();
      asserts++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h8 || out_imm !== 64'hAABBCCDD11223344 || out_imm_en !== 1'b1) begin
         $display("FAIL imm_bundle: got v=%b pc=%h inst=%h imm=%h imm_en=%b expected v=1 pc=0 inst=8 imm=aabbccdd11223344 imm_en=1",
                  out_valid, out_pc, out_inst, out_imm, out_imm_en); failures++; end
      tick();
      asserts++; if (out_valid !== 1'b1 || out_pc !== 32'hC || out_imm !== 64'h0 || out_imm_en !== 1'b0) begin
         $display("FAIL imm_next: got v=%b pc=%h imm=%h imm_en=%b expected v=1 pc=c imm=0 imm_en=0", out_valid, out_pc, out_imm, out_imm_en); failures++; end
   endtask

   task automatic test_backpressure();
      init_mem();
      out_ready = 1'b0;
      redirect_to(32'h0);
      for (int i = 0; i < 12 && out_count != 3'd4; i++) tick();
      asserts++; if (out_count !== 3'd4) begin $display("FAIL bp_fill: got count=%0d expected 4", out_count); failures++; end
      asserts++; if (imem_rd_en !== 1'b0 || imem_addr !== 32'h10) begin $display("FAIL bp_stall: got en=%b addr=%h expected en=0 addr=10", imem_rd_en, imem_addr); failures++; end
      tick(); tick();
      asserts++; if (out_count !== 3'd4 || imem_rd_en !== 1'b0 || imem_addr !== 32'h10) begin
         $display("FAIL bp_hold: got count=%0d en=%b addr=%h expected count=4 en=0 addr=10", out_count, imem_rd_en, imem_addr); failures++; end
      out_ready = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         asserts++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_inst !== (32'(k) << 4)) begin
            $display("FAIL bp_drain%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", k, out_valid, out_pc, out_inst, 32'(4 * k), 32'(k) << 4); failures++; end
         tick();
      end
   endtask

   task automatic test_redirect_mid_imm();
      init_mem();
      mem[8] = 32'h8; mem[9] = 32'hDEADBEEF; mem[10] = 32'h12345678; mem[16] = 32'h50;
      out_ready = 1'b1;
      redirect_to(32'h20);
      tick(); tick(); tick();
      redirect_en = 1'b1;
      redirect_pc = 32'h43;
      #1;
      asserts++; if (imem_rd_en !== 1'b0 || out_valid !== 1'b0) begin $display("FAIL redir_cycle: got en=%b v=%b expected en=0 v=0", imem_rd_en, out_valid); failures++; end
      tick();
      redirect_en = 1'b0;
      #1;
      asserts++; if (out_valid !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 32'h40) begin
         $display("FAIL redir_restart: got v=%b en=%b addr=%h expected v=0 en=1 addr=40", out_valid, imem_rd_en, imem_addr); failures++; end
      tick();
      asserts++; if (out_valid !== 1'b0) begin $display("FAIL redir_gap: got %b expected 0", out_valid); failures++; end
      tick();
      asserts++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h50 || out_imm_en !== 1'b0) begin
         $display("FAIL redir_bundle: got v=%b pc=%h inst=%h imm_en=%b expected v=1 pc=40 inst=50 imm_en=0", out_valid, out_pc, out_inst, out_imm_en); failures++; end
   endtask

   task automatic test_redirect_pop();
      init_mem();
      out_ready = 1'b0;
      redirect_to(32'h0);
      for (int i = 0; i < 12 && out_count != 3'd3; i++) tick();
      asserts++; if (out_count !== 3'd3) begin $display("FAIL rp_fill: got count=%0d expected 3", out_count); failures++; end
      out_ready   = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 32'h80;
      #1;
      asserts++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin $display("FAIL rp_head: got v=%b pc=%h expected v=1 pc=0", out_valid, out_pc); failures++; end
      tick();
      redirect_en = 1'b0;
      #1;
      asserts++; if (out_count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'h80) begin
         $display("FAIL rp_flush: got count=%0d v=%b addr=%h expected count=0 v=0 addr=80", out_count, out_valid, imem_addr); failures++; end
      tick(); tick();
      asserts++; if (out_valid !== 1'b1 || out_pc !== 32'h80 || out_inst !== 32'h200) begin
         $display("FAIL rp_next: got v=%b pc=%h inst=%h expected v=1 pc=80 inst=200", out_valid, out_pc, out_inst); failures++; end
   endtask

   task automatic test_pc_wrap();
      init_mem();
      mem[255] = 32'h8; mem[0] = 32'hCAFEF00D; mem[1] = 32'h01234567;
      out_ready = 1'b1;
      redirect_to(32'hFFFFFFFC);
      asserts++; if (imem_addr !== 32'hFFFFFFFC) begin $display("FAIL wrap_issue: got %h expected fffffffc", imem_addr); failures++; end
      tick();
      asserts++; if (imem_addr !== 32'h0) begin $display("FAIL wrap_addr: got %h expected 0", imem_addr); failures++; end
      tick(); tick(); tick();
      asserts++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFFFFFC || out_imm !== 64'h01234567CAFEF00D || out_imm_en !== 1'b1) begin
         $display("FAIL wrap_bundle: got v=%b pc=%h imm=%h imm_en=%b expected v=1 pc=fffffffc imm=01234567cafef00d imm_en=1",
                  out_valid, out_pc, out_imm, out_imm_en); failures++; end
      tick();
      asserts++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin $display("FAIL wrap_next: got v=%b pc=%h expected v=1 pc=8", out_valid, out_pc); failures++; end
   endtask

   task automatic test_async_reset();
      init_mem();
      mem[0] = 32'h5;
      out_ready = 1'b0;
      redirect_to(32'h0);
      tick(); tick(); tick();
      asserts++; if (out_valid !== 1'b1 || imem_rd_en !== 1'b1) begin $display("FAIL ar_pre: got v=%b en=%b expected v=1 en=1", out_valid, imem_rd_en); failures++; end
      #2;
      reset = 1'b0;
      #1;
      asserts++; if (imem_rd_en !== 1'b0 || out_valid !== 1'b0 || out_count !== 3'd0 || out_pc !== 32'h0) begin
         $display("FAIL ar_immediate: got en=%b v=%b count=%0d pc=%h expected en=0 v=0 count=0 pc=0", imem_rd_en, out_valid, out_count, out_pc); failures++; end
      tick();
      reset     = 1'b1;
      out_ready = 1'b1;
      #1;
      asserts++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
         $display("FAIL ar_restart: got en=%b addr=%h v=%b expected en=1 addr=0 v=0", imem_rd_en, imem_addr, out_valid); failures++; end
      tick(); tick();
      asserts++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h5) begin
         $display("FAIL ar_bundle: got v=%b pc=%h inst=%h expected v=1 pc=0 inst=5", out_valid, out_pc, out_inst); failures++; end
   endtask

   initial begin
      reset       = 1'b0;
      out_ready   = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 32'h0;
      init_mem();
      mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h4; mem[3] = 32'h10;
      #12;
      test_reset();
      test_straight_line();
      test_immediate();
      test_backpressure();
      test_redirect_mid_imm();
      test_redirect_pop();
      test_pc_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
